mc_cu: RTL and testbench



---
 rtl/mc_cu.sv | 168 ++++++++++++++++
 tb/tb_mc_cu.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_cu.sv
// rtl/mc_cu.sv - multi-cycle MIPS-subset control unit (IF/ID/EXE/MEM/WB) with retired-instruction counter
module mc_cu #(
  parameter int MEM_WAIT = 1,
  parameter int CNT_W    = 32,
  parameter int ALUC_W   = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [5:0]        op,
  input  logic [5:0]        func,
  input  logic              is_zero,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              iord,
  output logic              ir_we,
  output logic              pc_we,
  output logic              wmem,
  output logic              wreg,
  output logic              regrt,
  output logic              m2reg,
  output logic              shift,
  output logic              aluimm,
  output logic              sext,
  output logic              jal,
  output logic [ALUC_W-1:0] aluc,
  output logic [1:0]        pcsource,
  output logic [2:0]        state,
  output logic              illegal,
  output logic [CNT_W-1:0]  inst_count
);

  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EXE = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  logic r_type;
  logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
  logic i_addi, i_andi, i_ori, i_xori, i_lw, i_sw, i_beq, i_bne, i_lui, i_j, i_jal;
  logic legal, rdy, retire;
  logic [2:0] next_state;
  logic [3:0] aluc4;
  logic mem_req_c, ir_we_c, pc_we_c, wmem_c, wreg_c, illegal_c;

  assign r_type = (op == 6'b000000);
  assign i_add  = r_type & (func == 6'b100000);
  assign i_sub  = r_type & (func == 6'b100010);
  assign i_and  = r_type & (func == 6'b100100);
  assign i_or   = r_type & (func == 6'b100101);
  assign i_xor  = r_type & (func == 6'b100110);
  assign i_sll  = r_type & (func == 6'b000000);
  assign i_srl  = r_type & (func == 6'b000010);
  assign i_sra  = r_type & (func == 6'b000011);
  assign i_jr   = r_type & (func == 6'b001000);
  assign i_addi = (op == 6'b001000);
  assign i_andi = (op == 6'b001100);
  assign i_ori  = (op == 6'b001101);
  assign i_xori = (op == 6'b001110);
  assign i_lw   = (op == 6'b100011);
  assign i_sw   = (op == 6'b101011);
  assign i_beq  = (op == 6'b000100);
  assign i_bne  = (op == 6'b000101);
  assign i_lui  = (op == 6'b001111);
  assign i_j    = (op == 6'b000010);
  assign i_jal  = (op == 6'b000011);

  assign legal = i_add | i_sub | i_and | i_or | i_xor | i_sll | i_srl | i_sra | i_jr |
                 i_addi | i_andi | i_ori | i_xori | i_lw | i_sw | i_beq | i_bne |
                 i_lui | i_j | i_jal;

  assign regrt  = i_addi | i_andi | i_ori | i_xori | i_lw | i_lui;
  assign sext   = i_addi | i_lw | i_sw | i_beq | i_bne;
  assign aluimm = i_addi | i_andi | i_ori | i_xori | i_lw | i_sw | i_lui;
  assign shift  = i_sll | i_srl | i_sra;
  assign m2reg  = i_lw;
  assign jal    = i_jal;

  assign aluc4[3] = i_sra;
  assign aluc4[2] = i_sub | i_beq | i_bne | i_or | i_ori | i_lui | i_srl | i_sra;
  assign aluc4[1] = i_xor | i_xori | i_lui | i_sll | i_srl | i_sra;
  assign aluc4[0] = i_and | i_andi | i_or | i_ori | i_sll | i_srl | i_sra;

  always_comb begin
    aluc       = '0;
    aluc[3:0]  = aluc4;
  end

  assign rdy = (MEM_WAIT == 0) ? 1'b1 : mem_ready;

  always_comb begin
    next_state = S_IF;
    mem_req_c  = 1'b0;
    iord       = 1'b0;
    ir_we_c    = 1'b0;
    pc_we_c    = 1'b0;
    wmem_c     = 1'b0;
    wreg_c     = 1'b0;
    illegal_c  = 1'b0;
    pcsource   = 2'd0;
    case (state)
      S_IF: begin
        mem_req_c = 1'b1;
        if (rdy) begin
          ir_we_c    = 1'b1;
          pc_we_c    = 1'b1;
          next_state = S_ID;
        end else begin
          next_state = S_IF;
        end
      end
      S_ID: begin
        if (!legal) begin
          illegal_c = 1'b1;
        end else if (i_j | i_jal) begin
          pc_we_c  = 1'b1;
          pcsource = 2'd3;
          wreg_c   = i_jal;
        end else if (i_jr) begin
          pc_we_c  = 1'b1;
          pcsource = 2'd2;
        end else begin
          next_state = S_EXE;
        end
      end
      S_EXE: begin
        if (i_beq | i_bne) begin
          pcsource = 2'd1;
          pc_we_c  = (i_beq & is_zero) | (i_bne & ~is_zero);
        end else if (i_lw | i_sw) begin
          next_state = S_MEM;
        end else begin
          next_state = S_WB;
        end
      end
      S_MEM: begin
        mem_req_c = 1'b1;
        iord      = 1'b1;
        wmem_c    = i_sw;
        if (rdy) next_state = i_lw ? S_WB : S_IF;
        else     next_state = S_MEM;
      end
      S_WB: wreg_c = 1'b1;
      default: next_state = S_IF;
    endcase
  end

  // Enables are gated by resetn so nothing writes while reset is held, whatever mem_ready does.
  assign mem_req = mem_req_c & resetn;
  assign ir_we   = ir_we_c   & resetn;
  assign pc_we   = pc_we_c   & resetn;
  assign wmem    = wmem_c    & resetn;
  assign wreg    = wreg_c    & resetn;
  assign illegal = illegal_c & resetn;

  assign retire = legal && (next_state == S_IF) && (state >= S_ID) && (state <= S_WB);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IF;
      inst_count <= '0;
    end else begin
      state <= next_state;
      if (retire) inst_count <= inst_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mc_cu.sv
// tb/tb_mc_cu.sv - directed self-checking bench for mc_cu (no-wait/4-bit-counter and wait/32-bit instances)
module tb_mc_cu;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic [5:0] op = 6'd0;
  logic [5:0] func = 6'd0;
  logic is_zero = 1'b0;
  logic mem_ready = 1'b1;

  logic mem_req_a, iord_a, ir_we_a, pc_we_a, wmem_a, wreg_a, regrt_a, m2reg_a, shift_a;
  logic aluimm_a, sext_a, jal_a, illegal_a;
  logic [3:0] aluc_a;
  logic [1:0] pcsource_a;
  logic [2:0] state_a;
  logic [3:0] inst_count_a;

  logic mem_req_b, iord_b, ir_we_b, pc_we_b, wmem_b, wreg_b, regrt_b, m2reg_b, shift_b;
  logic aluimm_b, sext_b, jal_b, illegal_b;
  logic [3:0] aluc_b;
  logic [1:0] pcsource_b;
  logic [2:0] state_b;
  logic [31:0] inst_count_b;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011, OP_ORI = 6'b001101, OP_LUI = 6'b001111;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_SRA = 6'b000011, F_JR = 6'b001000;

  always #5 clock = ~clock;

  mc_cu #(.MEM_WAIT(0), .CNT_W(4), .ALUC_W(4)) dut_a (
    .clock(clock), .resetn(resetn), .op(op), .func(func), .is_zero(is_zero),
    .mem_ready(mem_ready), .mem_req(mem_req_a), .iord(iord_a), .ir_we(ir_we_a),
    .pc_we(pc_we_a), .wmem(wmem_a), .wreg(wreg_a), .regrt(regrt_a), .m2reg(m2reg_a),
    .shift(shift_a), .aluimm(aluimm_a), .sext(sext_a), .jal(jal_a), .aluc(aluc_a),
    .pcsource(pcsource_a), .state(state_a), .illegal(illegal_a), .inst_count(inst_count_a)
  );

  mc_cu dut_b (
    .clock(clock), .resetn(resetn), .op(op), .func(func), .is_zero(is_zero),
    .mem_ready(mem_ready), .mem_req(mem_req_b), .iord(iord_b), .ir_we(ir_we_b),
    .pc_we(pc_we_b), .wmem(wmem_b), .wreg(wreg_b), .regrt(regrt_b), .m2reg(m2reg_b),
    .shift(shift_b), .aluimm(aluimm_b), .sext(sext_b), .jal(jal_b), .aluc(aluc_b),
    .pcsource(pcsource_b), .state(state_b), .illegal(illegal_b), .inst_count(inst_count_b)
  );

  task automatic restart(input logic [5:0] o, input logic [5:0] f);
    @(negedge clock);
    resetn = 1'b0;
    op = o;
    func = f;
    mem_ready = 1'b1;
    @(negedge clock);
    resetn = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    @(negedge clock);
    resetn = 1'b0;
    mem_ready = 1'b1;
    op = OP_R;
    func = F_ADD;
    repeat (2) @(negedge clock);
    checks++;
    if ({state_a, state_b, pc_we_a, pc_we_b, ir_we_a, ir_we_b, wreg_b, wmem_b, illegal_b} !== 15'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got st_a=%0d st_b=%0d pcwe=%b%b irwe=%b%b wreg=%b wmem=%b ill=%b, want all 0",
               state_a, state_b, pc_we_a, pc_we_b, ir_we_a, ir_we_b, wreg_b, wmem_b, illegal_b);
    end
    checks++;
    if (inst_count_a !== 4'd0 || inst_count_b !== 32'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d/%0d, want 0/0", inst_count_a, inst_count_b);
    end
  endtask

  task automatic test_add_nowait;
    logic [2:0] exp_st [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    restart(OP_R, F_ADD);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (state_a !== exp_st[i] || wreg_a !== (exp_st[i] == 3'd4)) begin
        errors++;
        $display("FAIL add_seq[%0d]: got state=%0d wreg=%b, want state=%0d wreg=%b",
                 i, state_a, wreg_a, exp_st[i], exp_st[i] == 3'd4);
      end
      if (i < 4) @(negedge clock);
    end
    checks++;
    if (inst_count_a !== 4'd1) begin
      errors++;
      $display("FAIL add_count: got %0d, want 1", inst_count_a);
    end
  endtask

  task automatic test_cycle_counts;
    logic [5:0] ops [6] = '{OP_J, OP_JAL, OP_BNE, OP_R, OP_SW, OP_LW};
    logic [5:0] fns [6] = '{6'd0, 6'd0, 6'd0, F_JR, 6'd0, 6'd0};
    int exp_cyc [6] = '{2, 3, 3, 2, 4, 5};
    int cyc;
    exp_cyc[1] = 2;
    for (int k = 0; k < 6; k++) begin
      is_zero = 1'b0;
      restart(ops[k], fns[k]);
      cyc = 0;
      do begin
        @(negedge clock);
        cyc++;
      end while (state_a !== 3'd0 && cyc < 20);
      checks++;
      if (cyc !== exp_cyc[k] || inst_count_a !== 4'd1) begin
        errors++;
        $display("FAIL cycles[%0d]: got %0d cycles count=%0d, want %0d cycles count=1",
                 k, cyc, inst_count_a, exp_cyc[k]);
      end
    end
  endtask

  task automatic test_jump;
    restart(OP_JAL, 6'd0);
    @(negedge clock);
    checks++;
    if (state_a !== 3'd1 || pc_we_a !== 1'b1 || pcsource_a !== 2'd3 || wreg_a !== 1'b1) begin
      errors++;
      $display("FAIL jal_id: got st=%0d pcwe=%b pcsrc=%0d wreg=%b, want 1 1 3 1",
               state_a, pc_we_a, pcsource_a, wreg_a);
    end
    restart(OP_R, F_JR);
    @(negedge clock);
    checks++;
    if (state_a !== 3'd1 || pc_we_a !== 1'b1 || pcsource_a !== 2'd2 || wreg_a !== 1'b0) begin
      errors++;
      $display("FAIL jr_id: got st=%0d pcwe=%b pcsrc=%0d wreg=%b, want 1 1 2 0",
               state_a, pc_we_a, pcsource_a, wreg_a);
    end
  endtask

  task automatic test_lw_wait;
    restart(OP_LW, 6'd0);
    repeat (2) @(negedge clock);
    checks++;
    if (state_b !== 3'd2) begin
      errors++;
      $display("FAIL lw_exe: got state=%0d, want 2", state_b);
    end
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checks++;
      if (state_b !== 3'd3 || mem_req_b !== 1'b1 || iord_b !== 1'b1 || wreg_b !== 1'b0 || wmem_b !== 1'b0) begin
        errors++;
        $display("FAIL lw_hold[%0d]: got st=%0d req=%b iord=%b wreg=%b wmem=%b, want 3 1 1 0 0",
                 k, state_b, mem_req_b, iord_b, wreg_b, wmem_b);
      end
    end
    mem_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (state_b !== 3'd4 || m2reg_b !== 1'b1 || wreg_b !== 1'b1) begin
      errors++;
      $display("FAIL lw_wb: got st=%0d m2reg=%b wreg=%b, want 4 1 1", state_b, m2reg_b, wreg_b);
    end
    @(negedge clock);
    checks++;
    if (state_b !== 3'd0 || inst_count_b !== 32'd1) begin
      errors++;
      $display("FAIL lw_done: got st=%0d count=%0d, want 0 1", state_b, inst_count_b);
    end
  endtask

  task automatic test_branch;
    is_zero = 1'b1;
    restart(OP_BEQ, 6'd0);
    repeat (2) @(negedge clock);
    checks++;
    if (state_b !== 3'd2 || pc_we_b !== 1'b1 || pcsource_b !== 2'd1) begin
      errors++;
      $display("FAIL beq_exe: got st=%0d pcwe=%b pcsrc=%0d, want 2 1 1", state_b, pc_we_b, pcsource_b);
    end
    @(negedge clock);
    checks++;
    if (state_b !== 3'd0 || inst_count_b !== 32'd1) begin
      errors++;
      $display("FAIL beq_done: got st=%0d count=%0d, want 0 1", state_b, inst_count_b);
    end
    restart(OP_BNE, 6'd0);
    repeat (2) @(negedge clock);
    checks++;
    if (state_b !== 3'd2 || pc_we_b !== 1'b0 || pcsource_b !== 2'd1) begin
      errors++;
      $display("FAIL bne_exe: got st=%0d pcwe=%b pcsrc=%0d, want 2 0 1", state_b, pc_we_b, pcsource_b);
    end
    @(negedge clock);
    checks++;
    if (state_b !== 3'd0) begin
      errors++;
      $display("FAIL bne_done: got st=%0d, want 0", state_b);
    end
    is_zero = 1'b0;
  endtask

  task automatic test_illegal;
    restart(6'b111111, 6'd0);
    @(negedge clock);
    checks++;
    if (state_b !== 3'd1 || illegal_b !== 1'b1 || pc_we_b !== 1'b0 || wreg_b !== 1'b0) begin
      errors++;
      $display("FAIL ill_id: got st=%0d ill=%b pcwe=%b wreg=%b, want 1 1 0 0",
               state_b, illegal_b, pc_we_b, wreg_b);
    end
    @(negedge clock);
    checks++;
    if (state_b !== 3'd0 || illegal_b !== 1'b0 || inst_count_b !== 32'd0) begin
      errors++;
      $display("FAIL ill_after: got st=%0d ill=%b count=%0d, want 0 0 0", state_b, illegal_b, inst_count_b);
    end
  endtask

  task automatic test_decode;
    logic [5:0] ops [6] = '{OP_R, OP_ORI, OP_R, OP_LUI, OP_LW, OP_JAL};
    logic [5:0] fns [6] = '{F_SUB, 6'd0, F_SRA, 6'd0, 6'd0, 6'd0};
    // {aluc, regrt, sext, aluimm, shift, m2reg, jal}
    logic [9:0] exp [6] = '{10'b0100_000000, 10'b0101_101000, 10'b1111_000100,
                            10'b0110_101000, 10'b0000_111010, 10'b0000_000001};
    for (int k = 0; k < 6; k++) begin
      op = ops[k];
      func = fns[k];
      #1;
      checks++;
      if ({aluc_b, regrt_b, sext_b, aluimm_b, shift_b, m2reg_b, jal_b} !== exp[k]) begin
        errors++;
        $display("FAIL decode[%0d]: got %b, want %b", k,
                 {aluc_b, regrt_b, sext_b, aluimm_b, shift_b, m2reg_b, jal_b}, exp[k]);
      end
    end
  endtask

  task automatic test_reset_in_mem;
    restart(OP_SW, 6'd0);
    repeat (2) @(negedge clock);
    mem_ready = 1'b0;
    @(negedge clock);
    checks++;
    if (state_b !== 3'd3 || wmem_b !== 1'b1) begin
      errors++;
      $display("FAIL sw_mem: got st=%0d wmem=%b, want 3 1", state_b, wmem_b);
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (wmem_b !== 1'b0 || state_b !== 3'd0 || inst_count_b !== 32'd0 || mem_req_b !== 1'b0) begin
      errors++;
      $display("FAIL sw_abort: got wmem=%b st=%0d count=%0d req=%b, want 0 0 0 0",
               wmem_b, state_b, inst_count_b, mem_req_b);
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_wrap;
    restart(OP_J, 6'd0);
    repeat (30) @(negedge clock);
    checks++;
    if (inst_count_a !== 4'd15) begin
      errors++;
      $display("FAIL wrap_15: got %0d, want 15", inst_count_a);
    end
    repeat (2) @(negedge clock);
    checks++;
    if (inst_count_a !== 4'd0) begin
      errors++;
      $display("FAIL wrap_0: got %0d, want 0", inst_count_a);
    end
  endtask

  initial begin
    test_reset;
    test_add_nowait;
    test_cycle_counts;
    test_jump;
    test_lw_wait;
    test_branch;
    test_illegal;
    test_decode;
    test_reset_in_mem;
    test_wrap;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
